// File: rtl/fir_pkg.sv
// Shared types and constants for the symmetric 33-tap FIR sequencing controller.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_SHIFT,
        ST_READ,
        ST_DRAIN,
        ST_SUM
    } state_t;

    localparam int MAX_COEFF     = 17;
    localparam int RAM_DEPTH     = 16;
    localparam int COEFF_W       = 16;
    localparam int SAMPLE_PERIOD = 20;
    localparam int ADDR_W        = $clog2(RAM_DEPTH);

    // Active unique-coefficient count, saturated at the number the RAM pair can hold.
    function automatic logic [4:0] clamp_count(input logic [5:0] n, input int max_n);
        if (int'(n) > max_n) return 5'(max_n);
        return n[4:0];
    endfunction

endpackage

// File: rtl/fir_sym_mac_scheduler_if.sv
// Bundle of sample/coefficient inputs and SRAM/MAC control outputs of the FIR scheduler.
interface fir_sym_mac_scheduler_if;
    import fir_pkg::*;

    // No handshake: iEnSample600k is a one-cycle strobe taken only in IDLE, and each
    // cycle with iCoeffUpdateFlag high carries exactly one coefficient write (no backpressure).
    logic                iEnSample600k;
    logic                iCoeffUpdateFlag;
    logic [5:0]          iAddrRam;
    logic [COEFF_W-1:0]  iWrDtRam;
    logic [5:0]          iNumOfCoeff;

    logic                oCsnRam1;
    logic                oCsnRam2;
    logic                oWrnRam1;
    logic                oWrnRam2;
    logic [ADDR_W-1:0]   oAddrRam1;
    logic [ADDR_W-1:0]   oAddrRam2;
    logic [COEFF_W-1:0]  oWrDtRam1;
    logic [COEFF_W-1:0]  oWrDtRam2;
    logic                oEnDelay;
    logic                oAccClr;
    logic                oEnMac1;
    logic                oEnMac2;
    logic                oEnSum;
    logic                oBusy;
    logic                oOverrun;
    logic                oCoeffErr;

    modport master (
        input  iEnSample600k, iCoeffUpdateFlag, iAddrRam, iWrDtRam, iNumOfCoeff,
        output oCsnRam1, oCsnRam2, oWrnRam1, oWrnRam2, oAddrRam1, oAddrRam2,
               oWrDtRam1, oWrDtRam2, oEnDelay, oAccClr, oEnMac1, oEnMac2, oEnSum,
               oBusy, oOverrun, oCoeffErr
    );

    modport slave (
        output iEnSample600k, iCoeffUpdateFlag, iAddrRam, iWrDtRam, iNumOfCoeff,
        input  oCsnRam1, oCsnRam2, oWrnRam1, oWrnRam2, oAddrRam1, oAddrRam2,
               oWrDtRam1, oWrDtRam2, oEnDelay, oAccClr, oEnMac1, oEnMac2, oEnSum,
               oBusy, oOverrun, oCoeffErr
    );

endinterface

// File: rtl/fir_en_align.sv
// Delays the {EnMac1, EnMac2, AccClr} vector so MAC enables meet SRAM read data.
module fir_en_align #(
    parameter int W   = 3,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (LAT == 0) begin : g_pass
            assign q = d;
        end else begin : g_dly
            logic [W-1:0] pipe [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/fir_sym_mac_scheduler.sv
// Sequencer for the symmetric FIR: coefficient writes, per-sample shift/read/MAC/sum schedule.
module fir_sym_mac_scheduler #(
    parameter int RD_LAT    = 1,
    parameter int MAC_LAT   = 1,
    parameter int MAX_COEFF = 17
) (
    input  logic                           iClk12M,
    input  logic                           iRsn,
    fir_sym_mac_scheduler_if.master        bus,
    output fir_pkg::state_t                dbg_state
);
    import fir_pkg::*;

    // DRAIN covers the cycles between the last read on the pins and the sum capture.
    localparam int DRAIN_CYC = (RD_LAT + MAC_LAT > 1) ? RD_LAT + MAC_LAT - 1 : 1;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

    state_t               state;
    logic [4:0]           cnt;
    logic [4:0]           neff;
    logic [4:0]           r1;
    logic [4:0]           r2;
    logic [4:0]           rd_idx;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 rd1_act;
    logic                 rd2_act;
    logic                 first_rd;
    logic                 busy;
    logic [2:0]           en_vec;

    assign r1     = 5'((6'(neff) + 6'd1) >> 1);
    assign r2     = neff >> 1;
    assign rd_idx = (state == ST_SHIFT) ? 5'd0 : cnt;
    assign busy   = (state == ST_SHIFT) || (state == ST_READ) ||
                    (state == ST_DRAIN) || (state == ST_SUM);

    assign bus.oBusy = busy;
    assign dbg_state = state;

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            neff          <= '0;
            drain_cnt     <= '0;
            rd1_act       <= 1'b0;
            rd2_act       <= 1'b0;
            first_rd      <= 1'b0;
            bus.oCsnRam1  <= 1'b1;
            bus.oCsnRam2  <= 1'b1;
            bus.oWrnRam1  <= 1'b1;
            bus.oWrnRam2  <= 1'b1;
            bus.oAddrRam1 <= '0;
            bus.oAddrRam2 <= '0;
            bus.oWrDtRam1 <= '0;
            bus.oWrDtRam2 <= '0;
            bus.oEnDelay  <= 1'b0;
            bus.oEnSum    <= 1'b0;
            bus.oOverrun  <= 1'b0;
            bus.oCoeffErr <= 1'b0;
        end else begin
            bus.oCsnRam1  <= 1'b1;
            bus.oCsnRam2  <= 1'b1;
            bus.oWrnRam1  <= 1'b1;
            bus.oWrnRam2  <= 1'b1;
            bus.oAddrRam1 <= '0;
            bus.oAddrRam2 <= '0;
            bus.oWrDtRam1 <= '0;
            bus.oWrDtRam2 <= '0;
            bus.oEnDelay  <= 1'b0;
            bus.oEnSum    <= 1'b0;
            rd1_act       <= 1'b0;
            rd2_act       <= 1'b0;
            first_rd      <= 1'b0;

            if (bus.iEnSample600k && busy) bus.oOverrun <= 1'b1;

            case (state)
                ST_IDLE, ST_UPDATE: begin
                    // The update flag wins over a same-cycle strobe, which is then dropped.
                    if (bus.iCoeffUpdateFlag) begin
                        state <= ST_UPDATE;
                        if (bus.iAddrRam > 6'd16) begin
                            bus.oCoeffErr <= 1'b1;
                        end else if (!bus.iAddrRam[0]) begin
                            bus.oCsnRam1  <= 1'b0;
                            bus.oWrnRam1  <= 1'b0;
                            bus.oAddrRam1 <= ADDR_W'(bus.iAddrRam >> 1);
                            bus.oWrDtRam1 <= bus.iWrDtRam;
                        end else begin
                            bus.oCsnRam2  <= 1'b0;
                            bus.oWrnRam2  <= 1'b0;
                            bus.oAddrRam2 <= ADDR_W'(bus.iAddrRam >> 1);
                            bus.oWrDtRam2 <= bus.iWrDtRam;
                        end
                    end else if (state == ST_UPDATE) begin
                        state <= ST_IDLE;
                    end else if (bus.iEnSample600k) begin
                        state        <= ST_SHIFT;
                        bus.oEnDelay <= 1'b1;
                        neff         <= clamp_count(bus.iNumOfCoeff, MAX_COEFF);
                    end
                end

                ST_SHIFT, ST_READ: begin
                    // SHIFT issues read 0 itself; with Neff=0 the compare fails and READ is skipped.
                    if (rd_idx < r1) begin
                        state         <= ST_READ;
                        cnt           <= rd_idx + 5'd1;
                        bus.oCsnRam1  <= 1'b0;
                        bus.oAddrRam1 <= ADDR_W'(rd_idx);
                        rd1_act       <= 1'b1;
                        first_rd      <= (state == ST_SHIFT);
                        if (rd_idx < r2) begin
                            bus.oCsnRam2  <= 1'b0;
                            bus.oAddrRam2 <= ADDR_W'(rd_idx);
                            rd2_act       <= 1'b1;
                        end
                    end else begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
                        state      <= ST_SUM;
                        bus.oEnSum <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                ST_SUM: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fir_en_align #(
        .W   (3),
        .LAT (RD_LAT)
    ) u_en_align (
        .clk   (iClk12M),
        .rst_n (iRsn),
        .d     ({rd1_act, rd2_act, first_rd}),
        .q     (en_vec)
    );

    assign bus.oEnMac1 = en_vec[2];
    assign bus.oEnMac2 = en_vec[1];
    assign bus.oAccClr = en_vec[0];

endmodule

// File: tb/tb_fir_sym_mac_scheduler.sv
// Scenario bench for fir_sym_mac_scheduler: coefficient writes, sample schedules, overrun, reset abort.
module tb_fir_sym_mac_scheduler;
    import fir_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;
    logic ovr_model = 1'b0;
    logic err_model = 1'b0;

    logic [43:0] wr_exp_q[$];
    logic [16:0] trace_exp_q[$];

    always #5 clk = ~clk;

    fir_sym_mac_scheduler_if bus();

    fir_sym_mac_scheduler dut (
        .iClk12M   (clk),
        .iRsn      (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    function automatic logic [43:0] wr_word(input logic c1, input logic w1, input logic [3:0] a1,
                                            input logic [15:0] d1, input logic c2, input logic w2,
                                            input logic [3:0] a2, input logic [15:0] d2);
        return {c1, w1, a1, d1, c2, w2, a2, d2};
    endfunction

    function automatic logic [43:0] wr_obs();
        return wr_word(bus.oCsnRam1, bus.oWrnRam1, bus.oAddrRam1, bus.oWrDtRam1,
                       bus.oCsnRam2, bus.oWrnRam2, bus.oAddrRam2, bus.oWrDtRam2);
    endfunction

    function automatic logic [16:0] trace_obs();
        return {bus.oEnDelay, bus.oAccClr, bus.oEnMac1, bus.oEnMac2, bus.oEnSum,
                bus.oCsnRam1, bus.oCsnRam2, bus.oWrnRam1, bus.oWrnRam2,
                bus.oAddrRam1, bus.oAddrRam2};
    endfunction

    // Expected control trace at cycle n after a strobe in cycle 0 (RD_LAT = MAC_LAT = 1).
    function automatic logic [16:0] model_trace(input int n, input int neff);
        int r1;
        int r2;
        int sum_c;
        logic rd1;
        logic rd2;
        logic [3:0] a1;
        logic [3:0] a2;
        r1    = (neff + 1) / 2;
        r2    = neff / 2;
        sum_c = (r1 > 0) ? r1 + 3 : 3;
        rd1   = (n >= 2) && (n < 2 + r1);
        rd2   = (n >= 2) && (n < 2 + r2);
        a1    = rd1 ? 4'(n - 2) : 4'd0;
        a2    = rd2 ? 4'(n - 2) : 4'd0;
        return {(n == 1), (n == 3) && (r1 > 0), (n >= 3) && (n < 3 + r1), (n >= 3) && (n < 3 + r2),
                (n == sum_c), !rd1, !rd2, 1'b1, 1'b1, a1, a2};
    endfunction

    task automatic test_reset();
        logic [51:0] got;
        logic [51:0] exp;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = {bus.oCsnRam1, bus.oCsnRam2, bus.oWrnRam1, bus.oWrnRam2, bus.oAddrRam1, bus.oAddrRam2,
               bus.oWrDtRam1, bus.oWrDtRam2, bus.oEnDelay, bus.oAccClr, bus.oEnMac1, bus.oEnMac2,
               bus.oEnSum, bus.oBusy, bus.oOverrun, bus.oCoeffErr};
        exp = {4'b1111, 48'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, exp);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_coeff_load();
        logic [43:0] exp;
        logic [15:0] d;
        for (int i = 0; i <= 17; i++) begin
            @(posedge clk); #1;
            if (i < 17) begin
                d = 16'h1000 + 16'(i);
                bus.iCoeffUpdateFlag = 1'b1;
                bus.iAddrRam = 6'(i);
                bus.iWrDtRam = d;
                if (i % 2 == 0) wr_exp_q.push_back(wr_word(1'b0, 1'b0, 4'(i / 2), d, 1'b1, 1'b1, 4'd0, 16'd0));
                else            wr_exp_q.push_back(wr_word(1'b1, 1'b1, 4'd0, 16'd0, 1'b0, 1'b0, 4'(i / 2), d));
            end else begin
                bus.iCoeffUpdateFlag = 1'b0;
            end
            @(negedge clk);
            if (i >= 1) begin
                exp = wr_exp_q.pop_front();
                checks++;
                if (wr_obs() !== exp) begin
                    errors++;
                    $display("FAIL coeff_write k=%0d: got %h expected %h", i - 1, wr_obs(), exp);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (bus.oCoeffErr !== err_model || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL coeff_load_end: err %b state %0d expected err %b state IDLE",
                     bus.oCoeffErr, dbg_state, err_model);
        end
    endtask

    task automatic test_illegal_write();
        logic [43:0] exp;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.iCoeffUpdateFlag = (i < 2);
            bus.iAddrRam = (i == 0) ? 6'd20 : 6'd17;
            bus.iWrDtRam = 16'hBEEF;
            if (i < 2) wr_exp_q.push_back(wr_word(1'b1, 1'b1, 4'd0, 16'd0, 1'b1, 1'b1, 4'd0, 16'd0));
            @(negedge clk);
            if (i >= 1) begin
                exp = wr_exp_q.pop_front();
                err_model = 1'b1;
                checks++;
                if (wr_obs() !== exp) begin
                    errors++;
                    $display("FAIL illegal_no_access step %0d: got %h expected %h", i, wr_obs(), exp);
                end
                checks++;
                if (bus.oCoeffErr !== err_model) begin
                    errors++;
                    $display("FAIL coeff_err_set step %0d: got %b expected %b", i, bus.oCoeffErr, err_model);
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.oCoeffErr !== err_model || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL coeff_err_sticky: err %b state %0d expected err %b state IDLE",
                     bus.oCoeffErr, dbg_state, err_model);
        end
    endtask

    task automatic run_sample(input int num, input int strobe2);
        int neff;
        int sum_c;
        logic [16:0] exp;
        logic exp_busy;
        logic exp_ovr;
        logic ovr_hit;
        neff    = (num > 17) ? 17 : num;
        sum_c   = (neff > 0) ? (neff + 1) / 2 + 3 : 3;
        ovr_hit = (strobe2 >= 1) && (strobe2 <= sum_c);
        @(posedge clk); #1;
        bus.iNumOfCoeff = 6'(num);
        bus.iEnSample600k = 1'b1;
        for (int n = 0; n <= sum_c + 2; n++) trace_exp_q.push_back(model_trace(n, neff));
        for (int n = 0; n <= sum_c + 2; n++) begin
            @(negedge clk);
            exp = trace_exp_q.pop_front();
            checks++;
            if (trace_obs() !== exp) begin
                errors++;
                $display("FAIL trace N=%0d cycle %0d: got %h expected %h", num, n, trace_obs(), exp);
            end
            exp_busy = (n >= 1) && (n <= sum_c);
            checks++;
            if (bus.oBusy !== exp_busy) begin
                errors++;
                $display("FAIL busy N=%0d cycle %0d: got %b expected %b", num, n, bus.oBusy, exp_busy);
            end
            exp_ovr = ovr_model || (ovr_hit && n > strobe2);
            checks++;
            if (bus.oOverrun !== exp_ovr) begin
                errors++;
                $display("FAIL overrun N=%0d cycle %0d: got %b expected %b", num, n, bus.oOverrun, exp_ovr);
            end
            if (n == sum_c + 1) begin
                checks++;
                if (dbg_state !== ST_IDLE) begin
                    errors++;
                    $display("FAIL idle_after_sum N=%0d: got state %0d expected %0d", num, dbg_state, ST_IDLE);
                end
            end
            @(posedge clk); #1;
            bus.iEnSample600k = (n + 1 == strobe2);
        end
        bus.iEnSample600k = 1'b0;
        if (ovr_hit) ovr_model = 1'b1;
    endtask

    task automatic test_flag_priority();
        logic [43:0] exp;
        @(posedge clk); #1;
        bus.iEnSample600k = 1'b1;
        bus.iCoeffUpdateFlag = 1'b1;
        bus.iAddrRam = 6'd2;
        bus.iWrDtRam = 16'h2222;
        wr_exp_q.push_back(wr_word(1'b0, 1'b0, 4'd1, 16'h2222, 1'b1, 1'b1, 4'd0, 16'd0));
        @(posedge clk); #1;
        bus.iEnSample600k = 1'b0;
        bus.iCoeffUpdateFlag = 1'b0;
        @(negedge clk);
        exp = wr_exp_q.pop_front();
        checks++;
        if (wr_obs() !== exp) begin
            errors++;
            $display("FAIL prio_write: got %h expected %h", wr_obs(), exp);
        end
        checks++;
        if (dbg_state !== ST_UPDATE || bus.oEnDelay !== 1'b0 || bus.oBusy !== 1'b0 || bus.oOverrun !== ovr_model) begin
            errors++;
            $display("FAIL prio_state: state %0d en_delay %b busy %b overrun %b expected UPDATE,0,0,%b",
                     dbg_state, bus.oEnDelay, bus.oBusy, bus.oOverrun, ovr_model);
        end
        @(negedge clk);
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL prio_back_idle: got state %0d expected %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1;
        bus.iNumOfCoeff = 6'd17;
        bus.iEnSample600k = 1'b1;
        @(posedge clk); #1;
        bus.iEnSample600k = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.oCsnRam1 !== 1'b0 || bus.oAddrRam1 !== 4'd4) begin
            errors++;
            $display("FAIL midread_active: csn1 %b addr1 %0d expected 0 and 4", bus.oCsnRam1, bus.oAddrRam1);
        end
        rst_n = 1'b0;
        #1;
        ovr_model = 1'b0;
        err_model = 1'b0;
        checks++;
        if ({bus.oCsnRam1, bus.oCsnRam2, bus.oEnMac1, bus.oEnMac2, bus.oEnSum, bus.oBusy, bus.oCoeffErr} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_abort: csn %b%b mac %b%b sum %b busy %b err %b expected 11 00 0 0 0",
                     bus.oCsnRam1, bus.oCsnRam2, bus.oEnMac1, bus.oEnMac2, bus.oEnSum, bus.oBusy, bus.oCoeffErr);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if (bus.oEnSum !== 1'b0 || bus.oBusy !== 1'b0) begin
                errors++;
                $display("FAIL no_sum_after_reset cycle %0d: sum %b busy %b expected 0 0", n, bus.oEnSum, bus.oBusy);
            end
        end
        run_sample(17, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iEnSample600k = 1'b0;
        bus.iCoeffUpdateFlag = 1'b0;
        bus.iAddrRam = '0;
        bus.iWrDtRam = '0;
        bus.iNumOfCoeff = '0;
        test_reset();
        test_coeff_load();
        test_illegal_write();
        run_sample(17, -1);
        run_sample(5, -1);
        run_sample(0, -1);
        run_sample(40, -1);
        run_sample($urandom_range(1, 16), -1);
        test_flag_priority();
        run_sample(17, 8);
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
